// File: rtl/arb8_rr_if.sv
// arb8_rr request/grant bundle.
// master = requesting agents, slave = arbiter.
interface arb8_rr_if;
  logic [7:0] req;
  logic       done;
  logic [7:0] grant;
  logic       grant_valid;
  logic [2:0] grant_id;
  logic       timeout;

  modport master (
    output req,
    output done,
    input  grant,
    input  grant_valid,
    input  grant_id,
    input  timeout
  );

  modport slave (
    input  req,
    input  done,
    output grant,
    output grant_valid,
    output grant_id,
    output timeout
  );
endinterface

// File: rtl/arb8_rr.sv
// 8-way arbiter: rotating or fixed priority,
// registered one-hot grant, hold timeout, 1-cycle gap.
module arb8_rr #(
  parameter int RR       = 1,
  parameter int MAX_HOLD = 16
) (
  input logic   clk,
  input logic   reset_n,
  arb8_rr_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    GAP
  } state_t;

  localparam logic [7:0] LIM =
    8'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);

  function automatic logic [2:0] prio8(
    input logic [7:0] v
  );
    logic [2:0] r;
    r = 3'd0;
    priority case (1'b1)
      v[7]: r = 3'd7;
      v[6]: r = 3'd6;
      v[5]: r = 3'd5;
      v[4]: r = 3'd4;
      v[3]: r = 3'd3;
      v[2]: r = 3'd2;
      v[1]: r = 3'd1;
      v[0]: r = 3'd0;
      default: r = 3'd0;
    endcase
    return r;
  endfunction

  state_t     state, state_n;
  logic [7:0] grant_q, grant_n;
  logic [2:0] id_q, id_n;
  logic       gv_q;
  logic       to_q, to_n;
  logic [7:0] cnt, cnt_n;
  logic [2:0] ptr, ptr_n;

  logic [15:0] dbl;
  logic [7:0]  rot;
  logic [2:0]  win;
  logic        hit;
  logic        own_req;
  logic        rel;

  // rot[7] is req[ptr], rot[6] is req[ptr-1], ...
  assign dbl = {bus.req, bus.req};
  assign rot = 8'(dbl >> ({1'b0, ptr} + 4'd1));
  assign win = prio8(rot) + ptr + 3'd1;

  assign hit     = (MAX_HOLD != 0) && (cnt == LIM);
  assign own_req = bus.req[id_q];
  assign rel     = bus.done || !own_req || hit;

  always_comb begin
    state_n = state;
    grant_n = grant_q;
    id_n    = id_q;
    to_n    = 1'b0;
    cnt_n   = cnt;
    ptr_n   = ptr;
    unique case (state)
      IDLE: begin
        if (|bus.req) begin
          grant_n = 8'd1 << win;
          id_n    = win;
          cnt_n   = 8'd0;
          state_n = BUSY;
        end
      end
      BUSY: begin
        if (cnt != 8'hff)
          cnt_n = cnt + 8'd1;
        if (rel) begin
          grant_n = 8'd0;
          id_n    = 3'd0;
          state_n = GAP;
          to_n    = hit && !bus.done && own_req;
          if (RR != 0)
            ptr_n = id_q - 3'd1;
        end
      end
      GAP: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      grant_q <= 8'd0;
      id_q    <= 3'd0;
      gv_q    <= 1'b0;
      to_q    <= 1'b0;
      cnt     <= 8'd0;
      ptr     <= 3'd7;
    end else begin
      state   <= state_n;
      grant_q <= grant_n;
      id_q    <= id_n;
      gv_q    <= |grant_n;
      to_q    <= to_n;
      cnt     <= cnt_n;
      ptr     <= ptr_n;
    end
  end

  assign bus.grant       = grant_q;
  assign bus.grant_valid = gv_q;
  assign bus.grant_id    = id_q;
  assign bus.timeout     = to_q;

endmodule

// File: tb/tb_arb8_rr.sv
// Self-checking bench for arb8_rr: two configs
// (RR=1/MAX_HOLD=4 and RR=0/MAX_HOLD=0) vs a model.
module tb_arb8_rr;

  logic clk = 1'b0;
  logic rst_n;
  logic [7:0] r;
  logic d;

  int n_run = 0;
  int n_bad = 0;

  int m_busy[2];
  int m_gap[2];
  int m_own[2];
  int m_held[2];
  int m_ptr[2];
  int m_to[2];

  always #5 clk = ~clk;

  arb8_rr_if b0();
  arb8_rr_if b1();

  arb8_rr #(.RR(1), .MAX_HOLD(4)) u0 (
    .clk(clk), .reset_n(rst_n), .bus(b0.slave)
  );
  arb8_rr #(.RR(0), .MAX_HOLD(0)) u1 (
    .clk(clk), .reset_n(rst_n), .bus(b1.slave)
  );

  task automatic check(
    input string tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_run++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t",
               tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < 2; c++) begin
      m_busy[c] = 0;
      m_gap[c]  = 0;
      m_own[c]  = 0;
      m_held[c] = 0;
      m_ptr[c]  = 7;
      m_to[c]   = 0;
    end
  endtask

  task automatic model(input int c, input int rr,
                       input int mh);
    int hit, drop, a;
    m_to[c] = 0;
    if (m_gap[c] != 0) begin
      m_gap[c] = 0;
    end else if (m_busy[c] != 0) begin
      m_held[c]++;
      hit  = (mh != 0 && m_held[c] == mh) ? 1 : 0;
      drop = r[m_own[c]] ? 0 : 1;
      if (d || drop != 0 || hit != 0) begin
        m_busy[c] = 0;
        m_gap[c]  = 1;
        m_to[c]   = (hit != 0 && !d && drop == 0) ? 1 : 0;
        if (rr != 0) m_ptr[c] = (m_own[c] + 7) % 8;
      end
    end else if (r != 8'd0) begin
      for (int k = 7; k >= 0; k--) begin
        a = (m_ptr[c] - k + 8) % 8;
        if (r[a]) m_own[c] = a;
      end
      m_busy[c] = 1;
      m_held[c] = 0;
    end
  endtask

  function automatic logic [7:0] eg(input int c);
    return (m_busy[c] != 0) ? 8'(1 << m_own[c]) : 8'd0;
  endfunction

  task automatic compare();
    check("grant0", b0.grant, eg(0));
    check("gv0", b0.grant_valid, m_busy[0] != 0);
    check("id0", b0.grant_id,
          (m_busy[0] != 0) ? m_own[0] : 0);
    check("to0", b0.timeout, m_to[0]);
    check("oh0", $onehot0(b0.grant), 1);
    check("grant1", b1.grant, eg(1));
    check("gv1", b1.grant_valid, m_busy[1] != 0);
    check("id1", b1.grant_id,
          (m_busy[1] != 0) ? m_own[1] : 0);
    check("to1", b1.timeout, m_to[1]);
  endtask

  task automatic step();
    b0.req  = r;
    b1.req  = r;
    b0.done = d;
    b1.done = d;
    @(posedge clk);
    model(0, 1, 4);
    model(1, 0, 0);
    @(negedge clk);
    compare();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    r = 8'd0;
    d = 1'b0;
    b0.req = r; b1.req = r;
    b0.done = d; b1.done = d;
    model_reset();
    @(negedge clk);
    compare();
    rst_n = 1'b1;
  endtask

  initial begin
    int n0, n7, n1z, nto, ng;
    rst_n = 1'b0;
    r = 8'd0;
    d = 1'b0;
    b0.req = r; b1.req = r;
    b0.done = d; b1.done = d;
    model_reset();
    do_reset();

    for (int i = 0; i < 5; i++) step();

    // alternation vs fixed priority
    do_reset();
    r = 8'h81;
    n0 = 0; n7 = 0; n1z = 0;
    for (int i = 0; i < 30; i++) begin
      d = (m_busy[0] != 0 && m_held[0] == 2);
      step();
      if (b0.grant == 8'h01) n0++;
      if (b0.grant == 8'h80) n7++;
      if (b1.grant[0]) n1z++;
    end
    check("rr_agent0", n0 > 0, 1);
    check("rr_balance", n0 == n7 || n0 + 3 == n7 ||
          n7 + 3 == n0, 1);
    check("fixed_no0", n1z, 0);
    d = 1'b0;

    // timeout with req held
    do_reset();
    r = 8'h10;
    nto = 0; ng = 0;
    for (int i = 0; i < 14; i++) begin
      step();
      if (b0.timeout) nto++;
      if (b0.grant == 8'h10) ng++;
    end
    check("to_count", nto, 2);
    check("hold_cycles", ng, 10);

    // drop + done at the timeout cycle
    do_reset();
    r = 8'h08;
    for (int i = 0; i < 10; i++) begin
      step();
      if (m_busy[0] != 0 && m_held[0] == 3) break;
    end
    check("reach_cnt3", b0.grant, 8'h08);
    r = 8'h00;
    d = 1'b1;
    step();
    check("drop_no_to", b0.timeout, 0);
    check("drop_rel", b0.grant, 8'h00);
    d = 1'b0;

    // randomized traffic
    do_reset();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 5) == 0) r = 8'($urandom);
      d = ($urandom_range(0, 3) == 0);
      step();
    end

    // async reset mid-grant
    do_reset();
    r = 8'h04;
    d = 1'b0;
    step();
    step();
    check("pre_rst", b0.grant, 8'h04);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_g0", b0.grant, 8'h00);
    check("async_gv0", b0.grant_valid, 0);
    check("async_g1", b1.grant, 8'h00);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    r = 8'h05;
    step();
    check("post_rst", b0.grant, 8'h04);
    for (int i = 0; i < 6; i++) step();

    $display("[TB] %0d tests run, %0d failed",
             n_run, n_bad);
    $finish;
  end

endmodule

// File: doc/arb8_rr.md
Name: arb8_rr

Overview:
- 8-requester arbiter that shares one downstream resource, e.g. a shared bus or functional unit.
- Uses the team's 8-input priority-select function, MSB highest, applied to a rotated request vector.
- Issues a registered one-hot grant, holds it until the owner releases or a hold timeout fires, then re-arbitrates.
- Sits between the requesting agents and the resource mux; grant drives the mux select directly.

Parameters:
- RR, 1, 1 = round-robin priority rotation; 0 = fixed priority (bit 7 highest, bit 0 lowest).
- MAX_HOLD, 16, maximum grant duration in cycles before forced release; 0 = unlimited. Legal range 0..255.

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous active-low reset
- req  input  8  request per agent, level-sensitive, held until granted or abandoned
- done  input  1  current owner releases the resource this cycle
- grant  output  8  one-hot registered grant; all-zero when idle
- grant_valid  output  1  OR of grant, registered
- grant_id  output  3  binary index of the granted agent; 0 when idle
- timeout  output  1  one-cycle registered pulse: the grant was forcibly released by MAX_HOLD

Behaviour:
- Reset (reset_n=0, async) values:
  - grant=0, grant_valid=0, grant_id=0, timeout=0.
  - state=IDLE, hold counter=0, priority pointer ptr=7.
- Priority order: ptr, ptr-1, ..., 0, 7, ..., ptr+1 (mod 8). With RR=0, ptr is fixed at 7.
- FSM states: IDLE, BUSY, GAP.
  - IDLE:
    - If req!=0, select the winner w by priority order and go to BUSY.
    - grant, grant_id and grant_valid update at that same edge, so latency is 1 cycle from req sampled to grant visible.
    - If req==0, stay in IDLE.
  - BUSY: owner o = grant_id. Release when any of the following is true in a cycle:
    - done=1;
    - req[o]=0;
    - MAX_HOLD!=0 and the hold counter equals MAX_HOLD-1.
  - On release at an edge:
    - grant becomes 0 and state goes to GAP.
    - If RR=1, ptr becomes (o-1) mod 8.
    - timeout pulses high for exactly 1 cycle only if the release cause was the counter and neither done nor req drop was also present.
  - GAP: exactly one idle cycle for the resource mux turnaround; always proceeds to IDLE. Requests during GAP are not evaluated.
  - Minimum spacing between consecutive grants is therefore 2 cycles with grant=0.
- Hold counter:
  - 8 bits; cleared when entering BUSY, increments each BUSY cycle.
  - Saturates and is unused when MAX_HOLD=0.
  - A grant therefore lasts exactly MAX_HOLD cycles when timed out.
- Request changes by non-owners during BUSY are ignored; no preemption except by timeout.
- done asserted while in IDLE or GAP is ignored.
- grant is always one-hot or zero; grant_valid == |grant in every cycle.
- Reset asserted mid-grant: outputs clear immediately (asynchronously); after deassertion, arbitration restarts from ptr=7.

Test Plan:
- Reset then req=8'h00 for 5 cycles -> grant=0, grant_valid=0, timeout=0 throughout.
- RR=1, req=8'h81 held, done pulsed 3 cycles after each grant:
  - first grant=8'h80, id=7;
  - after GAP, grant=8'h01, id=0;
  - next grant=8'h80 again (alternation).
- RR=0, req=8'h81 held, done pulsed after each grant -> grant=8'h80 every time; agent 0 never granted.
- MAX_HOLD=4, req=8'h10 held, done=0:
  - grant=8'h10 for exactly 4 cycles;
  - timeout=1 for 1 cycle at release;
  - 1 GAP cycle, then re-grant 8'h10.
- Owner req[3] dropped and done=1 in the same cycle at hold count 3 (MAX_HOLD=4):
  - release at that edge;
  - timeout stays 0.
- reset_n pulsed low mid-BUSY with grant=8'h04:
  - grant=0 immediately, without waiting for a clock edge;
  - after release with req=8'h05, grant=8'h04 (ptr restored to 7).
